data_ram: RTL
=============

# data_ram

Parametrised, byte-addressed, little-endian data memory with sized accesses, a valid/ready request/response handshake, a configurable read pipeline and error reporting. It replaces the flat combinational-read word RAM on the core's load/store path. It serves byte, halfword and word loads/stores directly: sign/zero extension, alignment and bounds checks are done here, not in the core.

## Interface
- MEM_SIZE, 4096: memory size in bytes; power of two, >= 4.
- LATENCY, 1: response pipeline depth in cycles; legal range 1..4.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned: byte in [7:0], half in [15:0].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at a rising edge.
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  out  1  request was rejected.
- err_count  out  16  saturating count of rejected requests.

## Operation
- Access width N = 1, 2 or 4 bytes. Byte k of the access maps to mem[addr+k], with byte 0 least significant.
- Error conditions:
  - req_size = 11;
  - halfword with addr[0] = 1;
  - word with addr[1:0] != 0;
  - addr + N > MEM_SIZE, computed in 33 bits so there is no wrap-around.
- Errored request: no memory write, rsp_err = 1, rsp_rdata = 0, err_count increments unless it is already 0xFFFF.
- Store: on the accepting edge, write bytes addr..addr+N-1 from req_wdata[8N-1:0]. Other bytes are unchanged. The response carries rsp_err = 0 and rsp_rdata = 0.
- Load: the memory is sampled on the accepting edge and the result travels down the pipeline.
  - Extension uses bit 8N-1 of the loaded value unless req_unsigned = 1.
  - req_unsigned is ignored for words and for stores.
- Every accepted request produces exactly one response. Responses come back in acceptance order.
- Ordering: a store accepted at edge E is visible to a load accepted at edge E+1 or later. Within one edge, a load sees the old contents (it is accepted at a distinct edge anyway, since there is one request per edge).
- Pipeline: LATENCY stage registers (valid, err, rdata). Stage LATENCY drives the rsp_* outputs.
  - advance = !rsp_valid || rsp_ready.
  - When advance = 1, all stages shift by one. When advance = 0, all stages hold, including rsp_rdata and rsp_err.
  - req_ready = advance && rst_n (combinational). The request is dropped into stage 1 on an accepting edge. A bubble enters when there is no acceptance.
- Memory contents are not reset. The initial content is undefined.

## Timing
- Reset (rst_n low, asynchronous):
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, err_count = 0, all stage valids cleared;
  - req_ready = 0 while rst_n is low;
  - in-flight responses are discarded. A store already accepted before reset remains written.
- First cycle after deassertion: req_ready = 1.
- Latency: a request accepted in cycle t gives rsp_valid in cycle t+LATENCY when rsp_ready stays high.
- Throughput: one request per cycle with no bubbles while rsp_ready = 1.
- Backpressure: while rsp_valid && !rsp_ready, req_ready = 0, and the outputs and stages are frozen. The cycle rsp_ready rises, req_ready is 1 again in that same cycle.
- Simultaneous response consumption and request acceptance on one edge is legal, and is the steady state.
- err_count: updates on the accepting edge, not when the response is delivered. It saturates at 0xFFFF.

## Test plan
- Store word 0xDEADBEEF at 0x10, then load a byte at 0x11 (signed) -> rdata 0xFFFFFFBE. Load half at 0x12 unsigned -> 0x0000DEAD. Load word at 0x10 -> 0xDEADBEEF. Each response arrives exactly LATENCY cycles after acceptance.
- Store byte 0x5A at 0x13 over the word above, then load word 0x10 -> 0x5AADBEEF. Issue the store and load on back-to-back cycles -> the load sees the new byte.
- Half access at 0x21, word at 0x22, size 11, and word at MEM_SIZE-2 -> all four give rsp_err = 1 and rdata 0, and memory is unchanged on readback. err_count = 4.
- LATENCY = 3, stream 8 loads with rsp_ready toggling 1,0,0,1,... -> responses are in order, req_ready mirrors the stall, and no response is lost or duplicated.
- Assert rst_n low with 2 loads in flight -> rsp_valid drops immediately and err_count = 0. After release the first new load returns correctly and no stale responses appear.
- Drive 65540 erroring requests -> err_count holds at 0xFFFF.

Source files
------------

// File: rtl/data_ram.sv
// data_ram: byte-addressed little-endian data memory
// sized loads/stores, valid/ready handshake, read pipeline
module data_ram #(
  parameter int MEM_SIZE = 4096,
  parameter int LATENCY  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] err_count
);
  localparam int AW = $clog2(MEM_SIZE);

  logic [7:0]    mem [MEM_SIZE];
  logic          st_v [LATENCY];
  logic          st_e [LATENCY];
  logic [31:0]   st_d [LATENCY];

  logic          advance;
  logic          acc;
  logic [AW-1:0] ba [4];
  logic [2:0]    nbytes;
  logic          mis;
  logic          oob;
  logic          bad;
  logic [32:0]   end_addr;
  logic [31:0]   raw;
  logic [31:0]   ext;
  logic [31:0]   ld;
  logic          sgn_b;
  logic          sgn_h;

  assign advance   = !rsp_valid || rsp_ready;
  assign req_ready = advance && rst_n;
  assign acc       = req_valid && req_ready;

  assign rsp_valid = st_v[LATENCY-1];
  assign rsp_err   = st_e[LATENCY-1];
  assign rsp_rdata = st_d[LATENCY-1];

  // byte lane addresses; only used when in bounds
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      ba[k] = AW'(req_addr) + AW'(k);
    end
  end

  // size decode, error checks, load extraction
  always_comb begin
    nbytes = 3'd0;
    mis    = 1'b0;
    ext    = 32'h0;
    raw    = {mem[ba[3]], mem[ba[2]],
              mem[ba[1]], mem[ba[0]]};
    sgn_b  = raw[7] & ~req_unsigned;
    sgn_h  = raw[15] & ~req_unsigned;
    unique case (1'b1)
      req_size == 2'b00: begin
        nbytes = 3'd1;
        ext    = {{24{sgn_b}}, raw[7:0]};
      end
      req_size == 2'b01: begin
        nbytes = 3'd2;
        mis    = req_addr[0];
        ext    = {{16{sgn_h}}, raw[15:0]};
      end
      req_size == 2'b10: begin
        nbytes = 3'd4;
        mis    = |req_addr[1:0];
        ext    = raw;
      end
      default: begin
        mis    = 1'b1;
      end
    endcase
    end_addr = {1'b0, req_addr} + {30'd0, nbytes};
    oob      = end_addr > 33'(MEM_SIZE);
    bad      = mis | oob;
    ld       = (bad | req_we) ? 32'h0 : ext;
  end

  // store path; contents survive reset
  always_ff @(posedge clk) begin
    if (acc && req_we && !bad) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < nbytes) begin
          mem[ba[k]] <= req_wdata[8*k +: 8];
        end
      end
    end
  end

  // response pipeline, frozen under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        st_v[i] <= 1'b0;
        st_e[i] <= 1'b0;
        st_d[i] <= 32'h0;
      end
    end else if (advance) begin
      st_v[0] <= acc;
      st_e[0] <= acc & bad;
      st_d[0] <= acc ? ld : 32'h0;
      for (int i = 1; i < LATENCY; i++) begin
        st_v[i] <= st_v[i-1];
        st_e[i] <= st_e[i-1];
        st_d[i] <= st_d[i-1];
      end
    end
  end

  // saturating rejected-request counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 16'h0;
    end else if (acc && bad && err_count != 16'hFFFF) begin
      err_count <= err_count + 16'h1;
    end
  end
endmodule
